// File: rtl/apple_iie_timing_generator_pkg.sv
// Purpose: shared tick indices, field widths and phase decode for the timing generator and MMU.
// Latency: pure definitions; decode_tick is combinational.
// Backpressure: none.
// Contents: localparams for tick edges and blanking limits, strobes_t bundle, decode_tick().
package apple_iie_timing_generator_pkg;

    localparam int TICK_W = 5;
    localparam int H_W    = 7;
    localparam int V_W    = 9;

    // Tick indices, measured from the start of each half cycle (phi1 at t0, phi0 at t7).
    localparam logic [TICK_W-1:0] PHI0_START = 5'd7;
    localparam logic [TICK_W-1:0] Q3_TICKS   = 5'd4;
    localparam logic [TICK_W-1:0] RAS_FALL   = 5'd2;
    localparam logic [TICK_W-1:0] AX_FALL    = 5'd4;
    localparam logic [TICK_W-1:0] CAS_FALL   = 5'd4;

    localparam logic [H_W-1:0] HBLANK_END   = 7'd25;
    localparam logic [V_W-1:0] VBLANK_START = 9'd192;

    typedef struct packed {
        logic phi0;
        logic q3;
        logic pras_n;
        logic pcas_n;
        logic ax;
    } strobes_t;

    // Both halves share one strobe shape; the long-cycle stretch simply keeps
    // the phi0 half in its "CAS low" region for two extra ticks.
    function automatic strobes_t decode_tick(input logic [TICK_W-1:0] t);
        strobes_t          s;
        logic [TICK_W-1:0] ht;
        s.phi0   = (t >= PHI0_START);
        ht       = s.phi0 ? (t - PHI0_START) : t;
        s.q3     = (ht < Q3_TICKS);
        s.pras_n = (ht < RAS_FALL);
        s.ax     = (ht < AX_FALL);
        s.pcas_n = (ht < CAS_FALL);
        return s;
    endfunction

endpackage

// File: rtl/apple_iie_timing_generator_scan_counter.sv
// Purpose: horizontal/vertical scan counters with wrap and blanking flags.
// Latency: counters and flags registered; next-line/next-frame flags are combinational from next state.
// Backpressure: none; advances one CPU cycle whenever adv_i is high.
// Ports: clk_i, reset_i (sync, active high), adv_i (cycle-end strobe), last_cycle_o (hcount is the long
//        cycle), line_zero_d_o/frame_zero_d_o (next state is hcount 0 / hcount 0 + vcount 0),
//        hcount_o, vcount_o, hblank_o, vblank_o.
module apple_iie_scan_counter
    import apple_iie_timing_generator_pkg::*;
#(
    parameter int CYCLES_PER_LINE = 65,
    parameter int LINES_PER_FRAME = 262
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           adv_i,
    output logic           last_cycle_o,
    output logic           line_zero_d_o,
    output logic           frame_zero_d_o,
    output logic [H_W-1:0] hcount_o,
    output logic [V_W-1:0] vcount_o,
    output logic           hblank_o,
    output logic           vblank_o
);

    localparam logic [H_W-1:0] H_LAST = H_W'(CYCLES_PER_LINE - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(LINES_PER_FRAME - 1);

    logic [H_W-1:0] hcount_q, hcount_d;
    logic [V_W-1:0] vcount_q, vcount_d;
    logic           hblank_q, vblank_q;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (adv_i) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + V_W'(1);
            end else begin
                hcount_d = hcount_q + H_W'(1);
            end
        end
    end

    // Blank flags come from next state so they change on tick 0 of the cycle, with hcount.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblank_q <= (hcount_d < HBLANK_END);
            vblank_q <= (vcount_d >= VBLANK_START);
        end
    end

    assign last_cycle_o   = (hcount_q == H_LAST);
    assign line_zero_d_o  = (hcount_d == '0);
    assign frame_zero_d_o = (hcount_d == '0) && (vcount_d == '0);
    assign hcount_o       = hcount_q;
    assign vcount_o       = vcount_q;
    assign hblank_o       = hblank_q;
    assign vblank_o       = vblank_q;

endmodule

// File: rtl/apple_iie_timing_generator.sv
// Purpose: master tick sequencer: 14M -> CPU phases, DRAM RAS/CAS/AX, colour clock, scan counters.
// Latency: every output registered from next state, so it tracks the tick counter with zero lag.
// Backpressure: none; free running off clk_14m, only reset interrupts it.
// Ports: clk_14m, reset (sync, active high); clk_phi_0/clk_phi_1/clk_q3/clk_7m/clk_color clocks;
//        pras_n/pcas_n/ax DRAM controls; video_slot; hcount/vcount/hblank/vblank; line_start/frame_start.
module apple_iie_timing_generator
    import apple_iie_timing_generator_pkg::*;
#(
    parameter int CYCLE_TICKS     = 14,
    parameter int LONG_EXTRA      = 2,
    parameter int CYCLES_PER_LINE = 65,
    parameter int LINES_PER_FRAME = 262
) (
    input  logic           clk_14m,
    input  logic           reset,
    output logic           clk_phi_0,
    output logic           clk_phi_1,
    output logic           clk_q3,
    output logic           clk_7m,
    output logic           clk_color,
    output logic           pras_n,
    output logic           pcas_n,
    output logic           ax,
    output logic           video_slot,
    output logic [H_W-1:0] hcount,
    output logic [V_W-1:0] vcount,
    output logic           hblank,
    output logic           vblank,
    output logic           line_start,
    output logic           frame_start
);

    localparam logic [TICK_W-1:0] T_LAST      = TICK_W'(CYCLE_TICKS - 1);
    localparam logic [TICK_W-1:0] T_LAST_LONG = TICK_W'(CYCLE_TICKS + LONG_EXTRA - 1);

    logic [TICK_W-1:0] t_q, t_d;
    logic [1:0]        div_q, div_d;
    logic              last_cycle, cyc_end, line_zero_d, frame_zero_d;
    strobes_t          strb_d, strb_q;
    logic              clk_7m_q, clk_color_q, line_start_q, frame_start_q;

    always_comb begin
        // The last cycle of each line runs LONG_EXTRA ticks longer, all inside phi0.
        cyc_end = (t_q == (last_cycle ? T_LAST_LONG : T_LAST));
        t_d     = cyc_end ? '0 : t_q + TICK_W'(1);
        // Colour divider ignores t entirely; 912-tick lines keep it line-locked.
        div_d   = div_q + 2'd1;
        strb_d  = decode_tick(t_d);
    end

    always_ff @(posedge clk_14m) begin
        if (reset) begin
            t_q           <= '0;
            div_q         <= '0;
            strb_q.phi0   <= 1'b0;
            strb_q.q3     <= 1'b1;
            strb_q.pras_n <= 1'b1;
            strb_q.pcas_n <= 1'b1;
            strb_q.ax     <= 1'b1;
            clk_7m_q      <= 1'b0;
            clk_color_q   <= 1'b0;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            t_q           <= t_d;
            div_q         <= div_d;
            strb_q        <= strb_d;
            clk_7m_q      <= div_d[0];
            clk_color_q   <= div_d[1];
            line_start_q  <= (t_d == '0) && line_zero_d;
            frame_start_q <= (t_d == '0) && frame_zero_d;
        end
    end

    apple_iie_scan_counter #(
        .CYCLES_PER_LINE (CYCLES_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_scan (
        .clk_i          (clk_14m),
        .reset_i        (reset),
        .adv_i          (cyc_end),
        .last_cycle_o   (last_cycle),
        .line_zero_d_o  (line_zero_d),
        .frame_zero_d_o (frame_zero_d),
        .hcount_o       (hcount),
        .vcount_o       (vcount),
        .hblank_o       (hblank),
        .vblank_o       (vblank)
    );

    assign clk_phi_0   = strb_q.phi0;
    assign clk_phi_1   = ~strb_q.phi0;
    assign video_slot  = ~strb_q.phi0;
    assign clk_q3      = strb_q.q3;
    assign pras_n      = strb_q.pras_n;
    assign pcas_n      = strb_q.pcas_n;
    assign ax          = strb_q.ax;
    assign clk_7m      = clk_7m_q;
    assign clk_color   = clk_color_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_apple_iie_timing_generator.sv
// Purpose: self-checking bench for apple_iie_timing_generator (full-size NTSC line plus a short-line
//          instance that reaches vblank and frame wrap quickly).
// Latency: outputs sampled on the falling edge, half a tick after the active edge.
// Backpressure: none.
module tb_apple_iie_timing_generator;

    logic clk_14m = 1'b0;
    always #5 clk_14m = ~clk_14m;

    logic rst;

    logic       phi0_a, phi1_a, q3_a, c7_a, cc_a, pras_a, pcas_a, ax_a, vs_a, hblank_a, vblank_a, ls_a, fs_a;
    logic [6:0] hcount_a;
    logic [8:0] vcount_a;
    logic       phi0_b, phi1_b, q3_b, c7_b, cc_b, pras_b, pcas_b, ax_b, vs_b, hblank_b, vblank_b, ls_b, fs_b;
    logic [6:0] hcount_b;
    logic [8:0] vcount_b;

    apple_iie_timing_generator dut_a (
        .clk_14m(clk_14m), .reset(rst),
        .clk_phi_0(phi0_a), .clk_phi_1(phi1_a), .clk_q3(q3_a), .clk_7m(c7_a), .clk_color(cc_a),
        .pras_n(pras_a), .pcas_n(pcas_a), .ax(ax_a), .video_slot(vs_a),
        .hcount(hcount_a), .vcount(vcount_a), .hblank(hblank_a), .vblank(vblank_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    apple_iie_timing_generator #(.CYCLES_PER_LINE(2), .LINES_PER_FRAME(200)) dut_b (
        .clk_14m(clk_14m), .reset(rst),
        .clk_phi_0(phi0_b), .clk_phi_1(phi1_b), .clk_q3(q3_b), .clk_7m(c7_b), .clk_color(cc_b),
        .pras_n(pras_b), .pcas_n(pcas_b), .ax(ax_b), .video_slot(vs_b),
        .hcount(hcount_b), .vcount(vcount_b), .hblank(hblank_b), .vblank(vblank_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    typedef struct packed {
        logic phi0, phi1, q3, pras_n, pcas_n, ax, vs, c7, cc, hblank, vblank, ls, fs;
        logic [6:0] h;
        logic [8:0] v;
    } obs_t;

    obs_t got_a, got_b;
    assign got_a = {phi0_a, phi1_a, q3_a, pras_a, pcas_a, ax_a, vs_a, c7_a, cc_a,
                    hblank_a, vblank_a, ls_a, fs_a, hcount_a, vcount_a};
    assign got_b = {phi0_b, phi1_b, q3_b, pras_b, pcas_b, ax_b, vs_b, c7_b, cc_b,
                    hblank_b, vblank_b, ls_b, fs_b, hcount_b, vcount_b};

    int n;      // ticks since the last reset tick (0 on every reset tick)
    int n_cmp;
    int n_bad;

    localparam int LINE_TICKS_A = 65 * 14 + 2;       // 912
    localparam int LINE_TICKS_B = 2 * 14 + 2;        // 30
    localparam int FRAME_TICKS_B = 200 * LINE_TICKS_B;

    function automatic obs_t reset_obs();
        obs_t r;
        r.phi0 = 1'b0; r.phi1 = 1'b1; r.q3 = 1'b1; r.pras_n = 1'b1; r.pcas_n = 1'b1; r.ax = 1'b1;
        r.vs = 1'b1; r.c7 = 1'b0; r.cc = 1'b0; r.hblank = 1'b1; r.vblank = 1'b0; r.ls = 1'b1; r.fs = 1'b1;
        r.h = 7'd0; r.v = 9'd0;
        return r;
    endfunction

    // Position in the frame from absolute tick count: every cycle is 14 ticks except the last of the line (16).
    function automatic obs_t model(input int nt, input int cpl, input int lpf);
        obs_t e;
        int line_len, pos, p, h, v, t;
        line_len = (cpl - 1) * 14 + 16;
        pos = nt % (line_len * lpf);
        v   = pos / line_len;
        p   = pos % line_len;
        h   = (p >= (cpl - 1) * 14) ? cpl - 1 : p / 14;
        t   = p - h * 14;
        e.phi0   = (t >= 7);
        e.phi1   = (t < 7);
        e.q3     = (t < 4) || (t >= 7 && t < 11);
        e.pras_n = (t < 2) || (t == 7) || (t == 8);
        e.pcas_n = !((t >= 4 && t < 7) || t >= 11);
        e.ax     = (t < 4) || (t >= 7 && t < 11);
        e.vs     = (t < 7);
        e.c7     = ((nt % 2) == 1);
        e.cc     = (((nt / 2) % 2) == 1);
        e.hblank = (h < 25);
        e.vblank = (v >= 192);
        e.ls     = (p == 0);
        e.fs     = (pos == 0);
        e.h      = 7'(h);
        e.v      = 9'(v);
        return e;
    endfunction

    task automatic step();
        @(posedge clk_14m);
        n = rst ? 0 : n + 1;
        @(negedge clk_14m);
    endtask

    task automatic test_reset();
        obs_t r;
        r = reset_obs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (got_a !== r) begin n_bad++; $display("FAIL reset_a tick%0d got=%h want=%h", i, got_a, r); end
            n_cmp++;
            if (got_b !== r) begin n_bad++; $display("FAIL reset_b tick%0d got=%h want=%h", i, got_b, r); end
        end
    endtask

    task automatic test_first_cycle();
        logic [13:0] phi0_pat, q3_pat, pras_pat, cas_pat;
        logic [4:0]  want, have;
        phi0_pat = 14'b00000001111111;
        q3_pat   = 14'b11110001111000;
        pras_pat = 14'b11000001100000;
        cas_pat  = 14'b11110001111000;
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) step();
            want = {phi0_pat[13-i], q3_pat[13-i], pras_pat[13-i], cas_pat[13-i], cas_pat[13-i]};
            have = {phi0_a, q3_a, pras_a, pcas_a, ax_a};
            n_cmp++;
            if (have !== want) begin n_bad++; $display("FAIL first_cycle t%0d phi0/q3/ras/cas/ax got=%b want=%b", i, have, want); end
        end
    endtask

    task automatic test_long_cycle();
        int   budget, len, ph;
        logic want_cas;
        budget = 0;
        while (hcount_a !== 7'd64 && budget < 1200) begin step(); budget++; end
        n_cmp++;
        if (hcount_a !== 7'd64) begin
            n_bad++; $display("FAIL long_reach hcount got=%0d want=64", hcount_a);
        end else begin
            len = 0; ph = 0;
            while (hcount_a === 7'd64 && len < 40) begin
                want_cas = !((len >= 4 && len < 7) || len >= 11);
                n_cmp++;
                if (pcas_a !== want_cas) begin n_bad++; $display("FAIL long_pcas t%0d got=%b want=%b", len, pcas_a, want_cas); end
                if (phi0_a === 1'b1) ph++;
                len++;
                step();
            end
            n_cmp++;
            if (len != 16) begin n_bad++; $display("FAIL long_len got=%0d want=16", len); end
            n_cmp++;
            if (ph != 9) begin n_bad++; $display("FAIL long_phi0 got=%0d want=9", ph); end
            n_cmp++;
            if ({hcount_a, ls_a} !== {7'd0, 1'b1}) begin
                n_bad++; $display("FAIL long_wrap hcount/line_start got=%0d/%b want=0/1", hcount_a, ls_a);
            end
        end
    endtask

    task automatic test_line_period();
        int cnt;
        for (int k = 0; k < 2; k++) begin
            step();
            cnt = 1;
            while (ls_a !== 1'b1 && cnt < 2000) begin step(); cnt++; end
            n_cmp++;
            if (cnt != LINE_TICKS_A) begin n_bad++; $display("FAIL line_period%0d got=%0d want=%0d", k, cnt, LINE_TICKS_A); end
        end
    endtask

    task automatic test_color();
        int         last_rise;
        logic       prev_cc, prev_c7;
        logic [1:0] start_phase;
        last_rise   = -1;
        prev_cc     = cc_a;
        prev_c7     = c7_a;
        start_phase = {cc_a, c7_a};
        for (int i = 1; i <= 1000; i++) begin
            step();
            n_cmp++;
            if (c7_a === prev_c7) begin n_bad++; $display("FAIL clk_7m_toggle i%0d got=%b want=%b", i, c7_a, ~prev_c7); end
            if (cc_a === 1'b1 && prev_cc === 1'b0) begin
                if (last_rise >= 0) begin
                    n_cmp++;
                    if (i - last_rise != 4) begin n_bad++; $display("FAIL color_period i%0d got=%0d want=4", i, i - last_rise); end
                end
                last_rise = i;
            end
            if (ls_a === 1'b1) begin
                n_cmp++;
                if ({cc_a, c7_a} !== start_phase) begin
                    n_bad++; $display("FAIL color_line_phase got=%b want=%b", {cc_a, c7_a}, start_phase);
                end
            end
            prev_cc = cc_a;
            prev_c7 = c7_a;
        end
    endtask

    task automatic test_mid_reset();
        int   budget;
        obs_t r;
        r = reset_obs();
        budget = 0;
        while (hcount_a !== 7'd30 && budget < 1000) begin step(); budget++; end
        n_cmp++;
        if (hcount_a !== 7'd30) begin n_bad++; $display("FAIL mid_reach hcount got=%0d want=30", hcount_a); end
        repeat (9) step();
        n_cmp++;
        if ({phi0_a, q3_a, pras_a, pcas_a, ax_a} !== 5'b11011) begin
            n_bad++; $display("FAIL mid_t9 strobes got=%b want=11011", {phi0_a, q3_a, pras_a, pcas_a, ax_a});
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (got_a !== r) begin n_bad++; $display("FAIL mid_reset_a got=%h want=%h", got_a, r); end
        n_cmp++;
        if (got_b !== r) begin n_bad++; $display("FAIL mid_reset_b got=%h want=%h", got_b, r); end
        rst = 1'b0;
        step();
        n_cmp++;
        if (got_a !== model(n, 65, 262)) begin n_bad++; $display("FAIL mid_release_a got=%h want=%h", got_a, model(n, 65, 262)); end
        n_cmp++;
        if (got_b !== model(n, 2, 200)) begin n_bad++; $display("FAIL mid_release_b got=%h want=%h", got_b, model(n, 2, 200)); end
    endtask

    task automatic test_blank();
        int   budget, cnt;
        logic prev;
        budget = 0;
        prev = hblank_a;
        while (hcount_a !== 7'd25 && budget < 1000) begin prev = hblank_a; step(); budget++; end
        n_cmp++;
        if ({prev, hblank_a} !== 2'b10) begin n_bad++; $display("FAIL hblank_edge got=%b want=10", {prev, hblank_a}); end
        n_cmp++;
        if (n % LINE_TICKS_A != 350) begin n_bad++; $display("FAIL hblank_tick got=%0d want=350", n % LINE_TICKS_A); end

        budget = 0;
        prev = vblank_b;
        while (vcount_b !== 9'd192 && budget < 8000) begin prev = vblank_b; step(); budget++; end
        n_cmp++;
        if ({prev, vblank_b, ls_b} !== 3'b011) begin n_bad++; $display("FAIL vblank_edge prev/vblank/line_start got=%b want=011", {prev, vblank_b, ls_b}); end
        n_cmp++;
        if (n % FRAME_TICKS_B != 192 * LINE_TICKS_B) begin
            n_bad++; $display("FAIL vblank_tick got=%0d want=%0d", n % FRAME_TICKS_B, 192 * LINE_TICKS_B);
        end

        budget = 0;
        while (fs_b !== 1'b1 && budget < 1000) begin step(); budget++; end
        n_cmp++;
        if ({fs_b, hcount_b, vcount_b} !== {1'b1, 7'd0, 9'd0}) begin
            n_bad++; $display("FAIL frame_wrap fs/h/v got=%b/%0d/%0d want=1/0/0", fs_b, hcount_b, vcount_b);
        end
        step();
        cnt = 1;
        while (fs_b !== 1'b1 && cnt < 7000) begin step(); cnt++; end
        n_cmp++;
        if (cnt != FRAME_TICKS_B) begin n_bad++; $display("FAIL frame_period got=%0d want=%0d", cnt, FRAME_TICKS_B); end
    endtask

    task automatic test_random();
        int len, k;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(40, 2000);
            for (int i = 0; i < len; i++) begin
                step();
                n_cmp++;
                if (got_a !== model(n, 65, 262)) begin n_bad++; $display("FAIL rand_a n=%0d got=%h want=%h", n, got_a, model(n, 65, 262)); end
                n_cmp++;
                if (got_b !== model(n, 2, 200)) begin n_bad++; $display("FAIL rand_b n=%0d got=%h want=%h", n, got_b, model(n, 2, 200)); end
            end
            rst = 1'b1;
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                step();
                n_cmp++;
                if (got_a !== reset_obs()) begin n_bad++; $display("FAIL rand_reset_a got=%h want=%h", got_a, reset_obs()); end
                n_cmp++;
                if (got_b !== reset_obs()) begin n_bad++; $display("FAIL rand_reset_b got=%h want=%h", got_b, reset_obs()); end
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        n     = 0;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        test_reset();
        test_first_cycle();
        test_long_cycle();
        test_line_period();
        test_color();
        test_mid_reset();
        test_blank();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
